// File: rtl/ring_timing_monitor.sv
// Lock/track monitor for a 6-phase one-hot ring: phase encode, revolution count, sticky faults.
// Optional RTM_PHASE_STROBES_EN adds phase_strobe, the accepted one-hot sample aligned with phase.
module ring_timing_monitor #(
    parameter int PHASES = 6,
    parameter int REV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PHASES-1:0] timing,
    input  logic              err_clr,
    output logic [2:0]        phase,
    output logic              phase_valid,
    output logic [REV_W-1:0]  rev_count,
    output logic              rev_wrap,
    output logic              err_onehot,
    output logic              err_seq
`ifdef RTM_PHASE_STROBES_EN
    ,
    output logic [PHASES-1:0] phase_strobe
`endif
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [PHASES-1:0] FIRST = {1'b1, {(PHASES-1){1'b0}}};
    localparam logic [PHASES-1:0] LAST  = {{(PHASES-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [PHASES-1:0] t_q;
    logic [PHASES-1:0] prev_q;
    logic [2:0]        phase_q;
    logic              valid_q;
    logic [REV_W-1:0]  rev_q;
    logic [REV_W-1:0]  rev_d;
    logic              wrap_q;
    logic              eoh_q;
    logic              eseq_q;

    logic              onehot;
    logic              legal;
    logic              accept;
    logic              rev_step;
    logic [PHASES-1:0] succ;
    logic [2:0]        idx;

    assign onehot = (t_q != '0) && ((t_q & (t_q - 1'b1)) == '0);
    assign succ   = {prev_q[0], prev_q[PHASES-1:1]};
    // The source may sit in its own reset, so only S0 is allowed to repeat.
    assign legal  = (t_q == succ) || ((t_q == prev_q) && (prev_q == FIRST));
    assign accept = en && onehot
                 && ((state_q == SYNC) || ((state_q == LOCKED) && legal));
    assign rev_step = (state_q == LOCKED) && accept
                   && (prev_q == LAST) && (t_q == FIRST);
    assign rev_d  = rev_q + REV_W'(1);

    always_comb begin
        idx = '0;
        for (int i = 0; i < PHASES; i++) begin
            if (t_q[i]) idx = 3'(PHASES - 1 - i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            t_q     <= '0;
            prev_q  <= FIRST;
            phase_q <= '0;
            valid_q <= 1'b0;
            rev_q   <= '0;
            wrap_q  <= 1'b0;
            eoh_q   <= 1'b0;
            eseq_q  <= 1'b0;
        end else begin
            t_q     <= timing;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            if (err_clr) begin
                eoh_q  <= 1'b0;
                eseq_q <= 1'b0;
            end
            if (accept) begin
                prev_q  <= t_q;
                phase_q <= idx;
                valid_q <= 1'b1;
            end
            if (rev_step) begin
                rev_q  <= rev_d;
                wrap_q <= &rev_q;
            end
            case (state_q)
                SYNC: begin
                    if (accept) state_q <= LOCKED;
                end
                LOCKED: begin
                    // Error sets come after the clear so a same-cycle set wins.
                    if (!en) begin
                        state_q <= SYNC;
                    end else if (!onehot) begin
                        state_q <= FAULT;
                        eoh_q   <= 1'b1;
                    end else if (!legal) begin
                        state_q <= FAULT;
                        eseq_q  <= 1'b1;
                    end
                end
                FAULT: begin
                    if (err_clr) state_q <= SYNC;
                end
                default: state_q <= SYNC;
            endcase
        end
    end

`ifdef RTM_PHASE_STROBES_EN
    logic [PHASES-1:0] strobe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= accept ? t_q : '0;
        end
    end

    assign phase_strobe = strobe_q;
`endif

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign rev_count   = rev_q;
    assign rev_wrap    = wrap_q;
    assign err_onehot  = eoh_q;
    assign err_seq     = eseq_q;

endmodule
